// File: rtl/mem_block_copier.sv
// Copies len words src_base -> dst_base on a single-port memory, overlap-safe, and sums the copied words.
// Latency: done 3*len+2 cycles after an accepted start; start is ignored while busy.
module mem_block_copier #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 42
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum,
    output logic              mem_en,
    output logic              mem_en_r,
    output logic              mem_en_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);
    typedef enum logic [2:0] {IDLE, CHECK, RD, CAP, WR, FIN} state_t;

    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] src_r, dst_r, len_r, i_r;
    logic              desc_r;

    logic [ADDR_W:0]   src_end, dst_end;
    logic              bounds_bad, overlap;
    logic [ADDR_W-1:0] i_nxt;

    // Request checks use the live inputs so done/error can be registered straight into the CHECK cycle.
    assign src_end    = {1'b0, src_base} + {1'b0, len};
    assign dst_end    = {1'b0, dst_base} + {1'b0, len};
    assign bounds_bad = (src_end > DEPTH) || (dst_end > DEPTH);
    assign overlap    = (dst_base > src_base) && ({1'b0, dst_base} < src_end);
    assign i_nxt      = i_r + ONE;

    function automatic logic [ADDR_W-1:0] offset(input logic [ADDR_W-1:0] idx);
        return desc_r ? (len_r - ONE - idx) : idx;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
            mem_en   <= 1'b0;
            mem_en_r <= 1'b0;
            mem_en_w <= 1'b0;
            mem_addr <= '0;
            mem_d    <= '0;
            src_r    <= '0;
            dst_r    <= '0;
            len_r    <= '0;
            i_r      <= '0;
            desc_r   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r    <= src_base;
                        dst_r    <= dst_base;
                        len_r    <= len;
                        desc_r   <= overlap;
                        i_r      <= '0;
                        checksum <= '0;
                        busy     <= 1'b1;
                        state    <= CHECK;
                        if (len == '0)
                            done <= 1'b1;
                        else if (bounds_bad)
                            error <= 1'b1;
                    end
                end
                CHECK: begin
                    if (done || error) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        mem_en   <= 1'b1;
                        mem_en_r <= 1'b1;
                        mem_addr <= src_r + offset(i_r);
                        state    <= RD;
                    end
                end
                RD: begin
                    mem_en   <= 1'b0;
                    mem_en_r <= 1'b0;
                    state    <= CAP;
                end
                CAP: begin
                    mem_d    <= mem_q;
                    checksum <= checksum + mem_q;
                    mem_en   <= 1'b1;
                    mem_en_w <= 1'b1;
                    mem_addr <= dst_r + offset(i_r);
                    state    <= WR;
                end
                WR: begin
                    mem_en_w <= 1'b0;
                    i_r      <= i_nxt;
                    if (i_nxt == len_r) begin
                        mem_en <= 1'b0;
                        done   <= 1'b1;
                        state  <= FIN;
                    end else begin
                        mem_en_r <= 1'b1;
                        mem_addr <= src_r + offset(i_nxt);
                        state    <= RD;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: behavioural memory plus a memmove-style reference model.
module tb_mem_block_copier;
    localparam int ADDR_W = 6, DATA_W = 16, DEPTH = 42;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_base = '0, dst_base = '0, len = '0;
    logic              busy, done, error, mem_en, mem_en_r, mem_en_w;
    logic [DATA_W-1:0] checksum, mem_d;
    logic [DATA_W-1:0] mem_q = '0;
    logic [ADDR_W-1:0] mem_addr;

    int checks = 0, passes = 0;

    logic [DATA_W-1:0] mem [0:63];
    int wr_log[$];
    int ev_log[$];
    int inv_bad = 0, done_cnt = 0, err_cnt = 0, en_cnt = 0;

    mem_block_copier #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done), .error(error), .checksum(checksum),
        .mem_en(mem_en), .mem_en_r(mem_en_r), .mem_en_w(mem_en_w),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read data, plus an access log.
    always @(posedge clk) begin
        if (mem_en && mem_en_w) mem[mem_addr] <= mem_d;
        if (mem_en && mem_en_r) mem_q <= mem[mem_addr];
        if (mem_en_w) begin
            wr_log.push_back(int'(mem_addr));
            ev_log.push_back(100 + int'(mem_addr));
        end
        if (mem_en_r) ev_log.push_back(int'(mem_addr));
        if (mem_en_r && mem_en_w) inv_bad++;
        if (mem_en && !mem_en_r && !mem_en_w) inv_bad++;
        if (!mem_en && (mem_en_r || mem_en_w)) inv_bad++;
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (mem_en) en_cnt++;
    end

    task automatic clear_log();
        wr_log.delete();
        ev_log.delete();
        inv_bad = 0; done_cnt = 0; err_cnt = 0; en_cnt = 0;
    endtask

    task automatic fill_random();
        for (int a = 0; a < 64; a++) mem[a] = 16'($urandom);
    endtask

    // Issues one request and returns the cycle (after acceptance) of the done/error pulse, -1 on timeout.
    task automatic run_req(input int s, input int d, input int l, output int end_cyc, output int busy_bad);
        @(negedge clk);
        clear_log();
        src_base = ADDR_W'(s); dst_base = ADDR_W'(d); len = ADDR_W'(l);
        start = 1'b1;
        end_cyc = -1;
        busy_bad = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1 || error === 1'b1) begin
                end_cyc = c;
                break;
            end
        end
        @(negedge clk);
        if (busy !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {busy, done, error}); else passes++;
        checks++; if ({mem_en, mem_en_r, mem_en_w} !== 3'b000) $display("FAIL reset_strobes got=%b want=000", {mem_en, mem_en_r, mem_en_w}); else passes++;
        checks++; if (mem_addr !== '0 || mem_d !== '0) $display("FAIL reset_addr_d got=%h/%h want=0/0", mem_addr, mem_d); else passes++;
        checks++; if (checksum !== '0) $display("FAIL reset_checksum got=%h want=0", checksum); else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ascending();
        int ec, bb, bad;
        fill_random();
        mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'hFFFF;
        run_req(0, 10, 4, ec, bb);
        checks++; if (ec !== 14) $display("FAIL asc_done_cycle got=%0d want=14", ec); else passes++;
        checks++; if (checksum !== 16'h0005) $display("FAIL asc_checksum got=%h want=0005", checksum); else passes++;
        bad = 0;
        for (int k = 0; k < 4; k++) if (mem[10+k] !== mem[k]) bad++;
        checks++; if (bad !== 0) $display("FAIL asc_dest_words got=%0d_bad want=0_bad", bad); else passes++;
        bad = (ev_log.size() == 8) ? 0 : 1;
        for (int k = 0; k < 4 && bad == 0; k++)
            if (ev_log[2*k] != k || ev_log[2*k+1] != 110 + k) bad++;
        checks++; if (bad !== 0) $display("FAIL asc_interleave got=%0d_events want=R0,W10..R3,W13", ev_log.size()); else passes++;
        checks++; if (done_cnt !== 1 || bb !== 0 || inv_bad !== 0) $display("FAIL asc_pulses got=done%0d/busybad%0d/inv%0d want=1/0/0", done_cnt, bb, inv_bad); else passes++;
    endtask

    task automatic test_overlap();
        int ec, bb;
        logic [DATA_W-1:0] a, b, c;
        fill_random();
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
        mem[5] = a; mem[6] = b; mem[7] = c;
        run_req(5, 6, 3, ec, bb);
        checks++; if (wr_log.size() != 3 || wr_log[0] != 8 || wr_log[1] != 7 || wr_log[2] != 6)
            $display("FAIL ovl_write_order got_n=%0d want=8,7,6", wr_log.size()); else passes++;
        checks++; if (mem[5] !== a || mem[6] !== a || mem[7] !== b || mem[8] !== c)
            $display("FAIL ovl_contents got=%h %h %h %h want=%h %h %h %h", mem[5], mem[6], mem[7], mem[8], a, a, b, c); else passes++;
        checks++; if (checksum !== 16'(a + b + c) || ec !== 11) $display("FAIL ovl_sum_cycle got=%h/%0d want=%h/11", checksum, ec, 16'(a + b + c)); else passes++;
    endtask

    task automatic test_bounds_error();
        int ec, bb;
        run_req(40, 0, 3, ec, bb);
        checks++; if (ec !== 1 || err_cnt !== 1 || done_cnt !== 0) $display("FAIL err_pulse got=cyc%0d/err%0d/done%0d want=1/1/0", ec, err_cnt, done_cnt); else passes++;
        checks++; if (en_cnt !== 0) $display("FAIL err_no_access got=%0d want=0", en_cnt); else passes++;
        checks++; if (bb !== 0) $display("FAIL err_busy got=%0d want=0", bb); else passes++;
    endtask

    task automatic test_zero_len();
        int ec, bb;
        run_req(3, 20, 0, ec, bb);
        checks++; if (ec !== 1 || done_cnt !== 1 || err_cnt !== 0) $display("FAIL zero_done got=cyc%0d/done%0d/err%0d want=1/1/0", ec, done_cnt, err_cnt); else passes++;
        checks++; if (checksum !== '0 || en_cnt !== 0) $display("FAIL zero_no_access got=%h/%0d want=0/0", checksum, en_cnt); else passes++;
    endtask

    task automatic test_busy();
        int bb = 0;
        @(negedge clk);
        clear_log();
        src_base = 6'd1; dst_base = 6'd30; len = 6'd2;
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) bb++;
            src_base = ADDR_W'($urandom_range(0, 30));
            len = ADDR_W'($urandom_range(1, 5));
        end
        start = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0) bb++;
        repeat (4) @(negedge clk);
        checks++; if (bb !== 0) $display("FAIL busy_window got=%0d_bad want=0", bb); else passes++;
        checks++; if (done_cnt !== 1 || wr_log.size() != 2) $display("FAIL busy_single got=done%0d/wr%0d want=1/2", done_cnt, wr_log.size()); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] src0, src1;
        fill_random();
        for (int k = 30; k < 35; k++) mem[k] = 16'hDEAD;
        src0 = mem[20]; src1 = mem[21];
        @(negedge clk);
        clear_log();
        src_base = 6'd20; dst_base = 6'd30; len = 6'd5;
        start = 1'b1;
        // Word 2 is written in cycle 10; reset lands on the edge that would start it.
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done, error, mem_en, mem_en_r, mem_en_w} !== 6'b0 || mem_addr !== '0 || checksum !== '0)
            $display("FAIL midrst_outputs got=%b/%h/%h want=0/0/0", {busy, done, error, mem_en, mem_en_r, mem_en_w}, mem_addr, checksum); else passes++;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (wr_log.size() != 2 || done_cnt !== 0 || err_cnt !== 0) $display("FAIL midrst_activity got=wr%0d/done%0d/err%0d want=2/0/0", wr_log.size(), done_cnt, err_cnt); else passes++;
        checks++; if (mem[30] !== src0 || mem[31] !== src1 || mem[32] !== 16'hDEAD || mem[33] !== 16'hDEAD || mem[34] !== 16'hDEAD)
            $display("FAIL midrst_mem got=%h %h %h want=%h %h DEAD", mem[30], mem[31], mem[32], src0, src1); else passes++;
    endtask

    task automatic test_random();
        int s, d, l, ec, bb, exp_cyc, bad;
        logic [DATA_W-1:0] old [0:63];
        logic [DATA_W-1:0] exp_mem [0:63];
        logic [DATA_W-1:0] exp_sum;
        bit exp_err;
        for (int n = 0; n < 25; n++) begin
            fill_random();
            l = $urandom_range(0, 12);
            s = $urandom_range(0, 45);
            d = ($urandom_range(0, 2) == 0) ? s + $urandom_range(0, 3) : $urandom_range(0, 45);
            if (d > 63) d = 63;
            for (int a = 0; a < 64; a++) begin old[a] = mem[a]; exp_mem[a] = mem[a]; end
            exp_sum = '0;
            exp_err = (l != 0) && (s + l > DEPTH || d + l > DEPTH);
            exp_cyc = (l == 0 || exp_err) ? 1 : 3 * l + 2;
            if (!exp_err)
                for (int k = 0; k < l; k++) begin
                    exp_mem[d+k] = old[s+k];
                    exp_sum = exp_sum + old[s+k];
                end
            run_req(s, d, l, ec, bb);
            bad = 0;
            for (int a = 0; a < DEPTH; a++) if (mem[a] !== exp_mem[a]) bad++;
            checks++; if (ec !== exp_cyc || err_cnt !== int'(exp_err) || done_cnt !== int'(!exp_err))
                $display("FAIL rand%0d_outcome src=%0d dst=%0d len=%0d got=cyc%0d/err%0d/done%0d want=%0d/%0d/%0d",
                         n, s, d, l, ec, err_cnt, done_cnt, exp_cyc, int'(exp_err), int'(!exp_err)); else passes++;
            checks++; if (bad !== 0 || (!exp_err && checksum !== exp_sum))
                $display("FAIL rand%0d_data got=%0d_bad/%h want=0_bad/%h", n, bad, checksum, exp_sum); else passes++;
            checks++; if (bb !== 0 || inv_bad !== 0) $display("FAIL rand%0d_busy_inv got=%0d/%0d want=0/0", n, bb, inv_bad); else passes++;
        end
    endtask

    initial begin
        fill_random();
        test_reset();
        test_ascending();
        test_overlap();
        test_bounds_error();
        test_zero_len();
        test_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
